// File: rtl/chacha20_stream_ctrl.sv
// ChaCha20 keystream controller: sequences block-core jobs and streams 16 words per block.
// Define CHACHA20_PREFETCH_EN to add a second block buffer so the core runs ahead of the drain.
module chacha20_stream_ctrl (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         cfg_valid,
   output logic         cfg_ready,
   input  logic [255:0] cfg_key,
   input  logic [95:0]  cfg_nonce,
   input  logic [31:0]  cfg_counter,
   input  logic [15:0]  cfg_nblocks,
   input  logic         abort,
   output logic         core_start,
   output logic [255:0] core_key,
   output logic [95:0]  core_nonce,
   output logic [31:0]  core_counter,
   input  logic         core_done,
   input  logic [511:0] core_keystream,
   output logic         ks_valid,
   input  logic         ks_ready,
   output logic [31:0]  ks_data,
   output logic         ks_last,
   output logic         busy,
   output logic         err_wrap
);

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DRAIN} state_t;

   state_t        r_state;
   logic [255:0]  r_key;
   logic [95:0]   r_nonce;
   logic [31:0]   r_counter;
   logic [15:0]   r_remain;
   logic [511:0]  r_buf;
   logic [3:0]    r_idx;
   logic          r_ks_valid;
   logic          r_bfinal;
   logic          r_core_start;
   logic          r_err_wrap;

   logic          w_busy;
   logic          w_xfer;
   logic          w_blk_end;
   logic          w_final;

   assign w_xfer    = r_ks_valid & ks_ready;
   assign w_blk_end = w_xfer & (r_idx == 4'd15);
   // The block in hand is the job's last if the count runs out or its counter is the top value.
   assign w_final   = (r_remain == 16'd1) | (r_counter == 32'hFFFF_FFFF);

`ifdef CHACHA20_PREFETCH_EN
   logic [511:0]  r_pbuf;
   logic          r_pvalid;
   logic          r_pfinal;
   logic          w_to_main;

   assign w_busy    = (r_state != S_IDLE) | r_ks_valid | r_pvalid;
   // A captured block goes straight to the drain buffer only when nothing is queued ahead of it.
   assign w_to_main = (~r_ks_valid | w_blk_end) & ~r_pvalid;
`else
   assign w_busy    = (r_state != S_IDLE);
`endif

   assign cfg_ready    = ~w_busy;
   assign busy         = w_busy;
   assign core_start   = r_core_start;
   assign core_key     = r_key;
   assign core_nonce   = r_nonce;
   assign core_counter = r_counter;
   assign ks_valid     = r_ks_valid;
   assign ks_data      = r_buf[31:0];
   assign ks_last      = r_ks_valid & r_bfinal & (r_idx == 4'd15);
   assign err_wrap     = r_err_wrap;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_key        <= '0;
         r_nonce      <= '0;
         r_counter    <= '0;
         r_remain     <= '0;
         r_buf        <= '0;
         r_idx        <= '0;
         r_ks_valid   <= 1'b0;
         r_bfinal     <= 1'b0;
         r_core_start <= 1'b0;
         r_err_wrap   <= 1'b0;
`ifdef CHACHA20_PREFETCH_EN
         r_pbuf       <= '0;
         r_pvalid     <= 1'b0;
         r_pfinal     <= 1'b0;
`endif
      end else if (abort && w_busy) begin
         r_state      <= S_IDLE;
         r_ks_valid   <= 1'b0;
         r_core_start <= 1'b0;
`ifdef CHACHA20_PREFETCH_EN
         r_pvalid     <= 1'b0;
`endif
      end else begin
         r_core_start <= 1'b0;
         if (w_xfer) begin
            r_buf <= {32'h0, r_buf[511:32]};
            r_idx <= r_idx + 4'd1;
         end
`ifdef CHACHA20_PREFETCH_EN
         if (w_blk_end) begin
            r_ks_valid <= r_pvalid;
            r_buf      <= r_pbuf;
            r_bfinal   <= r_pfinal;
            r_pvalid   <= 1'b0;
         end
`endif
         case (r_state)
            S_IDLE: begin
               if (cfg_valid && !w_busy) begin
                  r_key      <= cfg_key;
                  r_nonce    <= cfg_nonce;
                  r_counter  <= cfg_counter;
                  r_remain   <= cfg_nblocks;
                  r_err_wrap <= 1'b0;
                  if (cfg_nblocks != 16'd0) begin
                     r_state      <= S_START;
                     r_core_start <= 1'b1;
                  end
               end
            end
            S_START: r_state <= S_WAIT;
            S_WAIT: begin
               if (core_done) begin
`ifdef CHACHA20_PREFETCH_EN
                  r_remain  <= r_remain - 16'd1;
                  r_counter <= r_counter + 32'd1;
                  if (w_final && (r_remain != 16'd1))
                     r_err_wrap <= 1'b1;
                  if (w_to_main) begin
                     r_buf      <= core_keystream;
                     r_idx      <= '0;
                     r_ks_valid <= 1'b1;
                     r_bfinal   <= w_final;
                  end else begin
                     r_pbuf   <= core_keystream;
                     r_pvalid <= 1'b1;
                     r_pfinal <= w_final;
                  end
                  if (w_final)
                     r_state <= S_IDLE;
                  else if (w_to_main) begin
                     r_state      <= S_START;
                     r_core_start <= 1'b1;
                  end else
                     r_state <= S_DRAIN;
`else
                  r_buf      <= core_keystream;
                  r_idx      <= '0;
                  r_ks_valid <= 1'b1;
                  r_bfinal   <= w_final;
                  r_state    <= S_DRAIN;
`endif
               end
            end
            S_DRAIN: begin
`ifdef CHACHA20_PREFETCH_EN
               // Core is idle here, waiting for the queued buffer to move into the drain slot.
               if (!r_pvalid) begin
                  r_state      <= S_START;
                  r_core_start <= 1'b1;
               end
`else
               if (w_blk_end) begin
                  r_ks_valid <= 1'b0;
                  r_remain   <= r_remain - 16'd1;
                  r_counter  <= r_counter + 32'd1;
                  if (w_final) begin
                     r_state <= S_IDLE;
                     if (r_remain != 16'd1)
                        r_err_wrap <= 1'b1;
                  end else begin
                     r_state      <= S_START;
                     r_core_start <= 1'b1;
                  end
               end
`endif
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/chacha20_stream_ctrl.md
CHACHA20_STREAM_CTRL -- requirements
Module: chacha20_stream_ctrl

Interface
REQ-001 Parameter: none; all widths fixed by the ChaCha20 (RFC 8439) block format.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 cfg_valid / cfg_ready  input / output  1 / 1  job request handshake.
REQ-005 cfg_key / cfg_nonce / cfg_counter  input  256 / 96 / 32  key, nonce and first block counter of the job.
REQ-006 cfg_nblocks  input  16  number of 64-byte blocks to generate.
REQ-007 abort  input  1  cancel the current job.
REQ-008 core_start  output  1  one-cycle start pulse to the block core.
REQ-009 core_key / core_nonce / core_counter  output  256 / 96 / 32  operands to the core; held stable from core_start until core_done.
REQ-010 core_done / core_keystream  input  1 / 512  core completion and 16-word result; word i is bits [32i+31:32i].
REQ-011 ks_valid / ks_ready / ks_data / ks_last  output / input / output / output  1 / 1 / 32 / 1  keystream word stream.
REQ-012 busy / err_wrap  output  1 / 1  job active; sticky counter-overflow flag.

Function
REQ-013 States: IDLE, START, WAIT, DRAIN; cfg_ready=1 only in IDLE.
REQ-014 IDLE, cfg_valid=1: latch key, nonce, counter, nblocks; clear err_wrap; go to START next cycle.
REQ-015 IDLE, cfg_valid=1, cfg_nblocks=0: accept, generate nothing, stay IDLE.
REQ-016 START: core_start=1 for exactly one cycle; go to WAIT.
REQ-017 WAIT: first cycle core_done=1 captures core_keystream into the output buffer; go to DRAIN; ks_valid=1 on the next cycle, with word 0.
REQ-018 DRAIN: a word transfers when ks_valid and ks_ready are both 1; order is word 0..15; ks_data and ks_valid hold while ks_ready=0.
REQ-019 ks_last=1 with word 15 of the final block of the job only.
REQ-020 After word 15 transfers: decrement remaining blocks and increment the counter mod 2^32. If blocks remain, go to START; otherwise go to IDLE.
REQ-021 Wrap: if the block just finished used counter 0xFFFFFFFF and blocks remain, set err_wrap=1 and go to IDLE; the final emitted word then carries ks_last=1; no block with counter 0 is started.
REQ-022 abort=1 in any non-IDLE state: go to IDLE next cycle with ks_valid=0; any core_done still in flight is ignored. abort has priority over core_done and a word transfer in the same cycle.
REQ-023 busy = state is not IDLE (non-prefetch build; REQ-028 extends this).
REQ-024 core_done arriving outside WAIT is ignored.

Reset
REQ-025 reset_n=0 at a clock edge forces IDLE, including mid-job; the in-flight block is discarded.
REQ-026 Reset values: cfg_ready=1; core_start=0; ks_valid=0; ks_last=0; busy=0; err_wrap=0; core_* operands, ks_data and the buffers = 0.

Configuration
REQ-027 Macro CHACHA20_PREFETCH_EN undefined: single 512-bit buffer; the next core_start is issued only after word 15 transfers. ks_valid drops for at least core latency + 2 cycles between blocks.
REQ-028 Macro CHACHA20_PREFETCH_EN defined: a second 512-bit buffer is added. The next core_start is issued the cycle after a block is captured, if blocks remain and a buffer is free. With core latency < 16 cycles and ks_ready=1 throughout, ks_valid stays 1 across block boundaries. busy stays 1 while any buffer holds undrained words. Wrap (REQ-021) and abort (REQ-022) semantics are unchanged; abort also discards the prefetched buffer.

Verification
REQ-029 RFC vector: key 000102..1f, nonce 000000090000004a00000000, counter 1, nblocks 1, ks_ready=1 -> 16 words; word 0 = e4e7f110, word 1 = 15593bd1, word 15 with ks_last=1; busy=0 afterwards.
REQ-030 nblocks 3, counter 7 -> core_counter presented as 7, 8, 9; 48 words; ks_last only on word 48; prefetch build shows no ks_valid gap.
REQ-031 Backpressure: ks_ready toggles 1/0 every cycle -> ks_data stable while stalled; no word lost or duplicated across 16 words.
REQ-032 counter 0xFFFFFFFE, nblocks 4 -> two blocks (FFFFFFFE, FFFFFFFF) emitted; err_wrap=1; ks_last on word 32; no core_start with counter 0.
REQ-033 abort asserted in WAIT, and again after word 5 of DRAIN -> IDLE next cycle, ks_valid=0, cfg_ready=1; a later core_done produces no output.
REQ-034 reset_n=0 for one cycle mid-DRAIN -> all outputs at REQ-026 values on the next cycle; a new job then runs per REQ-029.
